// File: rtl/i2c_pkg.sv
// Shared types for the I2C command sequencer: command/response layouts and FSM encoding.
package i2c_pkg;
   localparam int ADDR_W  = 7;
   localparam int MEM_W   = 5;
   localparam int DATA_W  = 8;
   localparam int RETRY_W = 2;
   localparam int CMD_W   = ADDR_W + 1 + MEM_W + DATA_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              rw;        // 1 = write, 0 = read
      logic [MEM_W-1:0]  mem_addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic [DATA_W-1:0]  rdata;
      logic               ack_err;
      logic               timeout;
      logic               rw;
      logic [RETRY_W-1:0] retries;
   } rsp_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_RESP
   } state_t;
endpackage

// File: rtl/i2c_cmd_seq_if.sv
// Command, response and downstream-master signal bundle for i2c_cmd_seq.
interface i2c_cmd_seq_if;
   import i2c_pkg::*;

   logic                cmd_valid;
   logic                cmd_ready;
   logic [ADDR_W-1:0]   cmd_addr;
   logic                cmd_rw;
   logic [MEM_W-1:0]    cmd_mem_addr;
   logic [DATA_W-1:0]   cmd_wdata;

   logic                rsp_valid;
   logic                rsp_ready;
   logic [DATA_W-1:0]   rsp_rdata;
   logic                rsp_ack_err;
   logic                rsp_timeout;
   logic                rsp_rw;
   logic [RETRY_W-1:0]  rsp_retries;

   logic                m_en;
   logic [ADDR_W-1:0]   m_addr;
   logic                m_rw;
   logic [MEM_W-1:0]    m_mem_addr;
   logic [DATA_W-1:0]   m_data_wr;
   logic                m_busy;
   logic                m_ack_err;
   logic [DATA_W-1:0]   m_data_rd;

   // sequencer side
   modport slave (
      input  cmd_valid, cmd_addr, cmd_rw, cmd_mem_addr, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_ack_err, rsp_timeout, rsp_rw, rsp_retries,
      input  rsp_ready,
      output m_en, m_addr, m_rw, m_mem_addr, m_data_wr,
      input  m_busy, m_ack_err, m_data_rd
   );

   // command producer / response consumer / I2C master side
   modport master (
      output cmd_valid, cmd_addr, cmd_rw, cmd_mem_addr, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_ack_err, rsp_timeout, rsp_rw, rsp_retries,
      output rsp_ready,
      input  m_en, m_addr, m_rw, m_mem_addr, m_data_wr,
      output m_busy, m_ack_err, m_data_rd
   );
endinterface

// File: rtl/i2c_cmd_fifo.sv
// Command FIFO: power-of-two depth, pointers wrap naturally, push and pop may coincide.
module i2c_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 21
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             push_ok, pop_ok;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk)
      if (push_ok) mem[wr_ptr] <= wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/i2c_cmd_seq.sv
// Queues I2C commands and drives one transfer at a time into a downstream byte master.
// Define I2C_SEQ_RETRY_EN to reissue NACKed transfers up to MAX_RETRY times.
module i2c_cmd_seq
   import i2c_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int START_TO  = 8,
   parameter int MAX_RETRY = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   i2c_cmd_seq_if.slave           bus,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   idle
);
   localparam int TO_W = $clog2(START_TO + 1);
`ifdef I2C_SEQ_RETRY_EN
   localparam int RETRIES = MAX_RETRY;
`else
   // retry disabled: a NACK is reported on the first attempt
   localparam int RETRIES = 0 * MAX_RETRY;
`endif

   state_t             state;
   cmd_t               cmd_in, fifo_head, cmd_q;
   rsp_t               rsp_q;
   logic               full, empty, push, pop;
   logic               m_en_q, rsp_valid_q;
   logic [TO_W-1:0]    to_cnt;
   logic [RETRY_W-1:0] retry_cnt;

   assign cmd_in        = {bus.cmd_addr, bus.cmd_rw, bus.cmd_mem_addr, bus.cmd_wdata};
   assign bus.cmd_ready = rst & ~full;
   assign push          = bus.cmd_valid & bus.cmd_ready;
   assign pop           = (state == S_IDLE) & ~empty & ~bus.m_busy;

   i2c_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (cmd_in),
      .pop   (pop),
      .rdata (fifo_head),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         cmd_q       <= '0;
         rsp_q       <= '0;
         m_en_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         to_cnt      <= '0;
         retry_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: if (pop) begin
               cmd_q     <= fifo_head;
               retry_cnt <= '0;
               m_en_q    <= 1'b1;
               state     <= S_ISSUE;
            end
            S_ISSUE: begin
               m_en_q <= 1'b0;
               to_cnt <= '0;
               state  <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (bus.m_busy) begin
                  state <= S_WAIT_DONE;
               end else if (to_cnt == TO_W'(START_TO - 1)) begin
                  // master never started: report, never retried
                  rsp_q       <= '{rdata: '0, ack_err: 1'b0, timeout: 1'b1,
                                   rw: cmd_q.rw, retries: retry_cnt};
                  rsp_valid_q <= 1'b1;
                  state       <= S_RESP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_WAIT_DONE: if (!bus.m_busy) begin
               if (bus.m_ack_err && (retry_cnt < RETRY_W'(RETRIES))) begin
                  retry_cnt <= retry_cnt + 1'b1;
                  m_en_q    <= 1'b1;
                  state     <= S_ISSUE;
               end else begin
                  rsp_q.rdata   <= (!cmd_q.rw && !bus.m_ack_err) ? bus.m_data_rd : '0;
                  rsp_q.ack_err <= bus.m_ack_err;
                  rsp_q.timeout <= 1'b0;
                  rsp_q.rw      <= cmd_q.rw;
                  rsp_q.retries <= retry_cnt;
                  rsp_valid_q   <= 1'b1;
                  state         <= S_RESP;
               end
            end
            S_RESP: if (bus.rsp_ready) begin
               rsp_valid_q <= 1'b0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.m_en        = m_en_q;
   assign bus.m_addr      = cmd_q.addr;
   assign bus.m_rw        = cmd_q.rw;
   assign bus.m_mem_addr  = cmd_q.mem_addr;
   assign bus.m_data_wr   = cmd_q.wdata;

   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_q.rdata;
   assign bus.rsp_ack_err = rsp_q.ack_err;
   assign bus.rsp_timeout = rsp_q.timeout;
   assign bus.rsp_rw      = rsp_q.rw;
   assign bus.rsp_retries = rsp_q.retries;

   assign idle = empty & (state == S_IDLE);
endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Self-checking bench for i2c_cmd_seq: vector table, scoreboard queue and a behavioural I2C master.
module tb_i2c_cmd_seq;
   import i2c_pkg::*;

   localparam int DEPTH     = 4;
   localparam int START_TO  = 8;
   localparam int MAX_RETRY = 2;
`ifdef I2C_SEQ_RETRY_EN
   localparam int EXP_RETRY = MAX_RETRY;
`else
   localparam int EXP_RETRY = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [$clog2(DEPTH):0] fifo_level;
   logic idle;

   i2c_cmd_seq_if bus();

   i2c_cmd_seq #(.DEPTH(DEPTH), .START_TO(START_TO), .MAX_RETRY(MAX_RETRY)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .fifo_level (fifo_level),
      .idle       (idle)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rdfn(input logic [6:0] a, input logic [4:0] m);
      return {a[2:0], m} ^ 8'h5A;
   endfunction

   function automatic rsp_t mk_rsp(input logic [7:0] d, input logic ae, input logic to,
                                   input logic rw, input int ret);
      rsp_t r;
      r.rdata = d; r.ack_err = ae; r.timeout = to; r.rw = rw; r.retries = RETRY_W'(ret);
      return r;
   endfunction

   // ---------------- behavioural downstream master ----------------
   logic       mdl_noresp = 1'b0, mdl_nack = 1'b0, mdl_fn = 1'b0, mdl_hold = 1'b0;
   logic [7:0] mdl_rdata  = 8'h00;
   int         busy_len   = 3;
   int         en_cnt     = 0;
   int         en_cyc     = 0;
   cmd_t       cap        = '0;

   initial begin
      bus.m_busy = 1'b0; bus.m_ack_err = 1'b0; bus.m_data_rd = 8'h00;
      forever begin
         @(posedge clk); #1;
         if (bus.m_en) begin
            en_cnt++;
            en_cyc = cyc;
            cap = {bus.m_addr, bus.m_rw, bus.m_mem_addr, bus.m_data_wr};
            if (!mdl_noresp) begin
               bus.m_busy = 1'b1; bus.m_ack_err = 1'b0;
               repeat (busy_len) @(posedge clk);
               #1;
               bus.m_ack_err = mdl_nack;
               bus.m_data_rd = mdl_fn ? rdfn(cap.addr, cap.mem_addr) : mdl_rdata;
               bus.m_busy    = 1'b0;
            end
         end else begin
            bus.m_busy = mdl_hold;
         end
      end
   end

   // ---------------- response scoreboard ----------------
   rsp_t exp_q[$];
   always @(negedge clk) begin
      if (rst && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rsp_unexpected: got response %0h, expected none",
                     {bus.rsp_rdata, bus.rsp_ack_err, bus.rsp_timeout, bus.rsp_rw, bus.rsp_retries});
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            check("rsp", 32'({bus.rsp_rdata, bus.rsp_ack_err, bus.rsp_timeout, bus.rsp_rw,
                              bus.rsp_retries}), 32'(e));
         end
      end
   end

   task automatic push_cmd(input logic rw, input logic [6:0] a, input logic [4:0] m,
                           input logic [7:0] w, input bit track, input rsp_t e);
      bit ok = 1'b0;
      bus.cmd_valid = 1'b1; bus.cmd_rw = rw; bus.cmd_addr = a;
      bus.cmd_mem_addr = m; bus.cmd_wdata = w;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk); ok = bus.cmd_ready;
         @(posedge clk); #1;
      end
      check("push_accept", 32'(ok), 32'd1);
      if (ok && track) exp_q.push_back(e);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      check({"drain_", name}, 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic rw; logic [6:0] addr; logic [4:0] mem; logic [7:0] wdata;
      logic noresp; logic nack; logic [7:0] mrd;
      rsp_t exp; int pulses;
   } vec_t;
   vec_t vt[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_addr = '0;
      bus.cmd_mem_addr = '0; bus.cmd_wdata = '0; bus.rsp_ready = 1'b0;

      vt[0] = '{1'b1, 7'h50, 5'h03, 8'hA5, 1'b0, 1'b0, 8'h00, mk_rsp(8'h00, 0, 0, 1, 0), 1};
      vt[1] = '{1'b0, 7'h50, 5'h07, 8'h00, 1'b0, 1'b0, 8'h3C, mk_rsp(8'h3C, 0, 0, 0, 0), 1};
      vt[2] = '{1'b0, 7'h22, 5'h1F, 8'h11, 1'b0, 1'b0, 8'hFF, mk_rsp(8'hFF, 0, 0, 0, 0), 1};
      vt[3] = '{1'b1, 7'h7F, 5'h00, 8'h00, 1'b0, 1'b0, 8'h77, mk_rsp(8'h00, 0, 0, 1, 0), 1};
      vt[4] = '{1'b0, 7'h33, 5'h0A, 8'h00, 1'b1, 1'b0, 8'h44, mk_rsp(8'h00, 0, 1, 0, 0), 1};
      vt[5] = '{1'b1, 7'h48, 5'h05, 8'h5C, 1'b0, 1'b1, 8'h00,
                mk_rsp(8'h00, 1, 0, 1, EXP_RETRY), EXP_RETRY + 1};
      vt[6] = '{1'b0, 7'h01, 5'h12, 8'h00, 1'b0, 1'b1, 8'h99,
                mk_rsp(8'h00, 1, 0, 0, EXP_RETRY), EXP_RETRY + 1};
      vt[7] = '{1'b1, 7'h6E, 5'h1E, 8'hC3, 1'b1, 1'b0, 8'h00, mk_rsp(8'h00, 0, 1, 1, 0), 1};

      // reset state
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_rdata, bus.rsp_ack_err, bus.rsp_timeout,
                            bus.rsp_rw, bus.rsp_retries}), 32'd0);
      check("rst_m", 32'({bus.m_en, bus.m_addr, bus.m_rw, bus.m_mem_addr, bus.m_data_wr}), 32'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      // table-driven single transfers
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         en_cnt = 0;
         mdl_noresp = vt[i].noresp; mdl_nack = vt[i].nack; mdl_rdata = vt[i].mrd; mdl_fn = 1'b0;
         push_cmd(vt[i].rw, vt[i].addr, vt[i].mem, vt[i].wdata, 1'b1, vt[i].exp);
         wait_drain($sformatf("vec%0d", i));
         check($sformatf("pulses_vec%0d", i), 32'(en_cnt), 32'(vt[i].pulses));
         check($sformatf("mfields_vec%0d", i), 32'(cap),
               32'({vt[i].addr, vt[i].rw, vt[i].mem, vt[i].wdata}));
         check($sformatf("idle_vec%0d", i), 32'(idle), 32'd1);
      end

      // fill the FIFO behind a stalled response; order must be preserved
      mdl_noresp = 1'b0; mdl_nack = 1'b0; mdl_fn = 1'b1; en_cnt = 0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         push_cmd(1'b0, 7'(8'h10 + i), 5'(i * 3), 8'h00, 1'b1,
                  mk_rsp(rdfn(7'(8'h10 + i), 5'(i * 3)), 0, 0, 0, 0));
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("full_level", 32'(fifo_level), 32'd4);
      check("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("full_rsp_held", 32'(bus.rsp_valid), 32'd1);
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      wait_drain("fifo_order");
      check("fifo_pulses", 32'(en_cnt), 32'd5);

      // timeout latency: RESP exactly START_TO+1 cycles after the m_en cycle
      mdl_fn = 1'b0; mdl_noresp = 1'b1; en_cnt = 0; bus.rsp_ready = 1'b0;
      push_cmd(1'b1, 7'h2A, 5'h01, 8'h0F, 1'b1, mk_rsp(8'h00, 0, 1, 1, 0));
      begin
         bit seen = 1'b0;
         for (int k = 0; k < 60 && !seen; k++) begin
            @(posedge clk); #1;
            seen = bus.rsp_valid;
         end
         check("to_seen", 32'(seen), 32'd1);
         check("to_latency", 32'(cyc - en_cyc), 32'(START_TO + 1));
      end
      bus.rsp_ready = 1'b1;
      wait_drain("timeout");
      check("to_pulses", 32'(en_cnt), 32'd1);

      // no issue while the master reports busy
      mdl_noresp = 1'b0; mdl_hold = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      en_cnt = 0;
      push_cmd(1'b1, 7'h0C, 5'h04, 8'h3E, 1'b1, mk_rsp(8'h00, 0, 0, 1, 0));
      repeat (10) @(posedge clk);
      #1;
      check("hold_no_issue", 32'(en_cnt), 32'd0);
      check("hold_level", 32'(fifo_level), 32'd1);
      mdl_hold = 1'b0;
      wait_drain("hold");
      check("hold_pulses", 32'(en_cnt), 32'd1);

      // reset in the middle of a transfer with two commands queued
      busy_len = 20; en_cnt = 0;
      for (int i = 0; i < 3; i++) push_cmd(1'b1, 7'(i), 5'(i), 8'(i), 1'b0, '0);
      begin
         bit found = 1'b0;
         for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); #1;
            found = bus.m_busy && (fifo_level == 2);
         end
         check("mid_rst_setup", 32'(found), 32'd1);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("mid_rst_idle", 32'(idle), 32'd1);
      check("mid_rst_level", 32'(fifo_level), 32'd0);
      check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      begin
         bit any_rsp = 1'b0;
         repeat (40) begin
            @(posedge clk); #1;
            any_rsp |= bus.rsp_valid;
         end
         check("mid_rst_no_rsp", 32'(any_rsp), 32'd0);
      end
      check("mid_rst_pulses", 32'(en_cnt), 32'd1);
      check("mid_rst_idle_after", 32'(idle), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/i2c_cmd_seq.md
I2C_CMD_SEQ -- requirements
Module: i2c_cmd_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter START_TO, default 8, clocks to wait for m_busy to rise after m_en.
REQ-003 SHALL have parameter MAX_RETRY, default 2, NACK reissues (used only with I2C_SEQ_RETRY_EN).
REQ-004 Ports: clk  in  1  single clock; all logic on posedge.
REQ-005 Ports: rst  in  1  asynchronous, active-low reset.
REQ-006 Ports: cmd_valid in 1, cmd_ready out 1  command handshake.
REQ-007 Ports: cmd_addr in 7, cmd_rw in 1 (1=write, 0=read), cmd_mem_addr in 5, cmd_wdata in 8  command fields.
REQ-008 Ports: rsp_valid out 1, rsp_ready in 1  response handshake.
REQ-009 Ports: rsp_rdata out 8, rsp_ack_err out 1, rsp_timeout out 1, rsp_rw out 1, rsp_retries out 2  response fields.
REQ-010 Ports: m_en out 1, m_addr out 7, m_rw out 1, m_mem_addr out 5, m_data_wr out 8  to downstream I2C master.
REQ-011 Ports: m_busy in 1, m_ack_err in 1, m_data_rd in 8  from downstream I2C master.
REQ-012 Ports: fifo_level out clog2(DEPTH)+1  occupancy; idle out 1  FIFO empty and FSM in S_IDLE.

Function
REQ-013 Command accepted on clk edge with cmd_valid && cmd_ready; cmd_ready = !full; accept with full SHALL NOT occur.
REQ-014 FIFO SHALL be first-in first-out, wrap pointers modulo DEPTH, support simultaneous push and pop with level unchanged.
REQ-015 FSM states: S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_RESP.
REQ-016 S_IDLE -> S_ISSUE when FIFO non-empty and m_busy=0; head popped into an internal command register on that edge.
REQ-017 S_ISSUE: m_en=1 for exactly one cycle with m_* fields from command register; -> S_WAIT_BUSY.
REQ-018 m_addr/m_rw/m_mem_addr/m_data_wr SHALL hold stable from S_ISSUE until S_RESP exit.
REQ-019 S_WAIT_BUSY: m_busy=1 -> S_WAIT_DONE; START_TO cycles without m_busy -> S_RESP with rsp_timeout=1, rsp_ack_err=0.
REQ-020 S_WAIT_DONE: on m_busy falling (1 then 0) capture m_ack_err and m_data_rd (read) or 0 (write) -> S_RESP.
REQ-021 S_RESP: rsp_valid=1, fields stable until rsp_ready; handshake edge -> S_IDLE; next issue no earlier than following cycle.
REQ-022 rsp_rw SHALL echo the command's cmd_rw; rsp_rdata SHALL be 0 for writes, timeouts and NACKed transfers.
REQ-023 FIFO SHALL keep accepting commands while a transfer is in progress.
REQ-024 Minimum issue-to-issue spacing: m_en SHALL never be asserted while m_busy=1.

Reset
REQ-025 rst low asynchronously: FSM S_IDLE, FIFO empty, fifo_level=0, cmd_ready=0 while rst low, 1 after.
REQ-026 Reset values: m_en=0, all m_* fields 0, rsp_valid=0, all rsp_* 0, idle=1.
REQ-027 Reset mid-transfer SHALL discard in-flight and queued commands; no response emitted for them.

Configuration
REQ-028 Macro I2C_SEQ_RETRY_EN defined: on m_ack_err=1 in S_WAIT_DONE with retry count < MAX_RETRY, SHALL return to S_ISSUE with same command, count+1; rsp_retries reports count.
REQ-029 Macro undefined: no retry, NACK reported immediately, rsp_retries tied 0.
REQ-030 Timeouts SHALL never be retried in either configuration.

Structure
REQ-031 Shared package i2c_pkg SHALL hold FSM state encoding, command struct/field widths (7/1/5/8) and response field widths.
REQ-032 FIFO SHALL be a separate sub-module i2c_cmd_fifo (parameter DEPTH, width 21).

Verification
REQ-033 Write addr=0x50 mem=0x03 wdata=0xA5, master ACKs -> one m_en pulse, rsp_ack_err=0, rsp_rw=1, rsp_rdata=0x00.
REQ-034 Read addr=0x50 mem=0x07, master returns 0x3C -> rsp_rdata=0x3C, rsp_rw=0, rsp_ack_err=0.
REQ-035 Push 5 commands with DEPTH=4 and rsp_ready=0 -> cmd_ready low after 4th accepted beyond the popped one; responses emerge in push order.
REQ-036 m_busy held 0 after m_en -> rsp_timeout=1 after START_TO=8 cycles, no retry.
REQ-037 Master NACKs always, retry enabled, MAX_RETRY=2 -> 3 m_en pulses, rsp_ack_err=1, rsp_retries=2; disabled -> 1 pulse, rsp_retries=0.
REQ-038 rst low during S_WAIT_DONE with 2 queued -> idle=1, fifo_level=0, no rsp_valid afterwards.
